// File: rtl/seq_divider_8by4.sv
// Sequential restoring divider: unsigned dividend / divisor, one quotient bit per clock.
// start/busy/done handshake; divide-by-zero finishes immediately with dbz set.
module seq_divider_8by4 #(
  parameter int unsigned N_DIVIDEND = 8,
  parameter int unsigned N_DIVISOR  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N_DIVIDEND-1:0] dividend,
  input  logic [N_DIVISOR-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic                  dbz,
  output logic [N_DIVIDEND-1:0] quotient,
  output logic [N_DIVISOR-1:0]  remainder
);

  localparam int unsigned CNT_W = (N_DIVIDEND > 1) ? $clog2(N_DIVIDEND) : 1;
  localparam int unsigned R_W   = N_DIVISOR + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [N_DIVIDEND-1:0] dvd_q, dvd_d;   // dividend in, quotient bits shift in at LSB
  logic [N_DIVISOR-1:0]  dvs_q, dvs_d;
  logic [R_W-1:0]        r_q, r_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [N_DIVIDEND-1:0] quo_q, quo_d;
  logic [N_DIVISOR-1:0]  rem_q, rem_d;
  logic                  dbz_q, dbz_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [R_W-1:0]        r_sh;
  logic [R_W-1:0]        r_step;
  logic                  ge;
  logic [N_DIVIDEND-1:0] dvd_step;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, restoring step and output logic
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    r_sh     = {r_q[N_DIVISOR-1:0], dvd_q[N_DIVIDEND-1]};
    ge       = (r_sh >= {1'b0, dvs_q});
    r_step   = ge ? (r_sh - {1'b0, dvs_q}) : r_sh;
    dvd_step = {dvd_q[N_DIVIDEND-2:0], ge};

    unique case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d = dividend;
          dvs_d = divisor;
          r_d   = '0;
          cnt_d = '0;
          if (divisor == '0) begin
            state_d = DONE;
            dbz_d   = 1'b1;
            quo_d   = '1;
            rem_d   = '0;
          end else begin
            state_d = BUSY;
            dbz_d   = 1'b0;
          end
        end
      end
      BUSY: begin
        r_d   = r_step;
        dvd_d = dvd_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N_DIVIDEND - 1)) begin
          state_d = DONE;
          quo_d   = dvd_step;
          // The restored remainder is always below the divisor, so the top bit is zero here.
          rem_d   = r_step[N_DIVISOR-1:0];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == BUSY);
    done_d = (state_d == DONE);
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign dbz       = dbz_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule
